// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns 1/2/4-byte read/write requests into RAM byte cycles.
// Optional macro MEMCTRL_IO_WAIT_EN adds a wait cycle per byte for addresses with bit 17 set.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  rw_mem,
    input  logic [31:0] addr_to_mem,
    input  logic [31:0] data_to_mem,
    input  logic [3:0]  quantity,
    output logic [31:0] data_from_mem,
    output logic [1:0]  mem_status,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_buf;
    logic [31:0] r_data_from_mem;
    logic [31:0] r_mem_a;
    logic [7:0]  r_mem_dout;
    logic        r_mem_wr;
    logic        r_write;
    logic        r_wait;
    logic [2:0]  r_cnt;
    logic [2:0]  r_n;

    logic [2:0]  w_n_dec;
    logic [2:0]  w_cnt_inc;
    logic        w_req;
    logic        w_req_write;
    logic        w_io_wait;
    logic        w_cap;
    logic [1:0]  w_cap_idx;
    logic [31:0] w_addr_next;
    logic [31:0] w_buf_next;
    logic [7:0]  w_byte_next;
    logic        w_unused_qty;

    assign w_unused_qty = quantity[3];
    assign w_req        = (rw_mem == 3'b001) || (rw_mem == 3'b010);
    assign w_req_write  = (rw_mem == 3'b010);
    assign w_cnt_inc    = r_cnt + 3'd1;
    assign w_addr_next  = r_addr + {29'd0, w_cnt_inc};

`ifdef MEMCTRL_IO_WAIT_EN
    assign w_io_wait = r_addr[17];
`else
    assign w_io_wait = 1'b0;
`endif

    always_comb begin
        w_n_dec = 3'd4;
        case (quantity[2:0])
            3'd1:    w_n_dec = 3'd1;
            3'd2:    w_n_dec = 3'd2;
            default: w_n_dec = 3'd4;
        endcase
    end

    always_comb begin
        w_byte_next = r_buf[7:0];
        case (w_cnt_inc[1:0])
            2'd0: w_byte_next = r_buf[7:0];
            2'd1: w_byte_next = r_buf[15:8];
            2'd2: w_byte_next = r_buf[23:16];
            2'd3: w_byte_next = r_buf[31:24];
            default: w_byte_next = r_buf[7:0];
        endcase
    end

    // Read capture: RAM data trails the address by one cycle, so without wait
    // states byte cnt-1 lands while cnt is on screen; with waits it lands in the wait cycle.
    always_comb begin
        w_cap     = 1'b0;
        w_cap_idx = 2'd0;
        if (r_state == S_BUSY && !r_write) begin
            if (w_io_wait) begin
                w_cap     = r_wait;
                w_cap_idx = r_cnt[1:0];
            end else begin
                w_cap     = (r_cnt != 3'd0);
                w_cap_idx = r_cnt[1:0] - 2'd1;
            end
        end
        w_buf_next = r_buf;
        if (w_cap) begin
            case (w_cap_idx)
                2'd0: w_buf_next[7:0]   = mem_din;
                2'd1: w_buf_next[15:8]  = mem_din;
                2'd2: w_buf_next[23:16] = mem_din;
                2'd3: w_buf_next[31:24] = mem_din;
                default: w_buf_next = r_buf;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_addr          <= 32'd0;
            r_buf           <= 32'd0;
            r_data_from_mem <= 32'd0;
            r_mem_a         <= 32'd0;
            r_mem_dout      <= 8'd0;
            r_mem_wr        <= 1'b0;
            r_write         <= 1'b0;
            r_wait          <= 1'b0;
            r_cnt           <= 3'd0;
            r_n             <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mem_a    <= 32'd0;
                    r_mem_dout <= 8'd0;
                    r_mem_wr   <= 1'b0;
                    if (w_req) begin
                        r_state    <= S_BUSY;
                        r_addr     <= addr_to_mem;
                        r_write    <= w_req_write;
                        r_n        <= w_n_dec;
                        r_cnt      <= 3'd0;
                        r_wait     <= 1'b0;
                        r_buf      <= w_req_write ? data_to_mem : 32'd0;
                        r_mem_a    <= addr_to_mem;
                        r_mem_wr   <= w_req_write;
                        r_mem_dout <= w_req_write ? data_to_mem[7:0] : 8'd0;
                    end
                end
                S_BUSY: begin
                    r_buf <= w_buf_next;
                    if (w_io_wait && !r_wait && (r_cnt < r_n)) begin
                        // Wait cycle: address stays put, strobe drops.
                        r_wait     <= 1'b1;
                        r_mem_wr   <= 1'b0;
                        r_mem_dout <= 8'd0;
                    end else if (r_write) begin
                        r_wait <= 1'b0;
                        if (w_cnt_inc == r_n) begin
                            r_state    <= S_DONE;
                            r_mem_a    <= 32'd0;
                            r_mem_dout <= 8'd0;
                            r_mem_wr   <= 1'b0;
                        end else begin
                            r_cnt      <= w_cnt_inc;
                            r_mem_a    <= w_addr_next;
                            r_mem_dout <= w_byte_next;
                            r_mem_wr   <= 1'b1;
                        end
                    end else begin
                        r_wait     <= 1'b0;
                        r_mem_wr   <= 1'b0;
                        r_mem_dout <= 8'd0;
                        if (r_cnt == r_n) begin
                            r_state         <= S_DONE;
                            r_data_from_mem <= w_buf_next;
                            r_mem_a         <= 32'd0;
                        end else begin
                            r_cnt   <= w_cnt_inc;
                            r_mem_a <= (w_cnt_inc < r_n) ? w_addr_next : 32'd0;
                        end
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_mem_a    <= 32'd0;
                    r_mem_dout <= 8'd0;
                    r_mem_wr   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_status    = r_state;
    assign data_from_mem = r_data_from_mem;
    assign mem_a         = r_mem_a;
    assign mem_dout      = r_mem_dout;
    assign mem_wr        = r_mem_wr;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: vector table plus hand sequences for reset abort and back-to-back requests.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rw_mem;
    logic [31:0] addr_to_mem;
    logic [31:0] data_to_mem;
    logic [3:0]  quantity;
    logic [31:0] data_from_mem;
    logic [1:0]  mem_status;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .rw_mem        (rw_mem),
        .addr_to_mem   (addr_to_mem),
        .data_to_mem   (data_to_mem),
        .quantity      (quantity),
        .data_from_mem (data_from_mem),
        .mem_status    (mem_status),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [39:0] exp_q[$];       // expected RAM writes {addr, byte}
    logic [32:0] exp_done_q[$];  // one entry per DONE: {is_read, read data}

    logic [7:0] ram [logic [31:0]];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic int n_of(input logic [3:0] q);
        logic [2:0] lo;
        lo = q[2:0];
        if (lo == 3'd1) return 1;
        if (lo == 3'd2) return 2;
        return 4;
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // RAM model: read byte appears one cycle after the address.
    always @(posedge clk) mem_din <= ram_rd(mem_a);

    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            check("wr_only_in_busy", 40'(mem_status), 40'(2'b01));
            if (exp_q.size() == 0) begin
                check("unexpected_write", {mem_a, mem_dout}, 40'd0);
            end else begin
                check("write_addr_data", {mem_a, mem_dout}, exp_q.pop_front());
            end
            ram[mem_a] = mem_dout;
        end
        if (mem_status === 2'b10) begin
            if (exp_done_q.size() == 0) begin
                check("spurious_done", 40'(mem_status), 40'(2'b00));
            end else begin
                logic [32:0] e;
                e = exp_done_q.pop_front();
                if (e[32]) check("read_data", 40'(data_from_mem), 40'(e[31:0]));
            end
        end
    end

    typedef struct {
        logic [2:0]  rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  qty;
        logic [31:0] exp_rdata;
        int          exp_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v);
        int n;
        int busy;
        int cyc;
        logic [31:0] ea;
        logic [31:0] sh;
        n = n_of(v.qty);
        rw_mem      = v.rw;
        addr_to_mem = v.addr;
        data_to_mem = v.wdata;
        quantity    = v.qty;
        if (v.rw == 3'b010) begin
            for (int k = 0; k < n; k++) begin
                sh = v.wdata >> (8 * k);
                exp_q.push_back({v.addr + 32'(k), sh[7:0]});
            end
            exp_done_q.push_back({1'b0, 32'd0});
        end else begin
            exp_done_q.push_back({1'b1, v.exp_rdata});
        end
        @(posedge clk); #1;
        rw_mem = 3'b000;
        busy = 0;
        cyc  = 0;
        while (mem_status !== 2'b10 && cyc < 40) begin
            if (mem_status === 2'b01) begin
                busy++;
                if (v.rw == 3'b001) begin
                    ea = (busy - 1 < n) ? v.addr + 32'(busy - 1) : 32'd0;
                    check("read_mem_a", 40'(mem_a), 40'(ea));
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("reached_done", 40'(mem_status), 40'(2'b10));
        check("busy_cycles", 40'(busy), 40'(v.exp_busy));
        @(posedge clk); #1;
        check("idle_after_done", 40'(mem_status), 40'(2'b00));
    endtask

    logic [1:0] seq_exp[8];

    initial begin
        vecs[0] = '{3'b001, 32'h0000_0100, 32'h0,          4'd4,  32'h4433_2211, 5};
        vecs[1] = '{3'b010, 32'h0000_0200, 32'hAABB_CCDD, 4'd2,  32'h0,         2};
        vecs[2] = '{3'b001, 32'h0000_0000, 32'h0,          4'd1,  32'h0000_0080, 2};
        vecs[3] = '{3'b001, 32'h0000_01F0, 32'h0,          4'hA,  32'h0000_5455, 3};
        vecs[4] = '{3'b001, 32'hFFFF_FFFE, 32'h0,          4'd7,  32'hA480_5A5B, 5};
        vecs[5] = '{3'b010, 32'h0000_0300, 32'h1234_5678, 4'd0,  32'h0,         4};
        vecs[6] = '{3'b001, 32'h0000_0300, 32'h0,          4'd4,  32'h1234_5678, 5};
        vecs[7] = '{3'b010, 32'h0000_0400, 32'h0000_0099, 4'd1,  32'h0,         1};
        vecs[8] = '{3'b010, 32'hFFFF_FFFF, 32'h0000_BEEF, 4'd2,  32'h0,         2};
        vecs[9] = '{3'b001, 32'hFFFF_FFFF, 32'h0,          4'd2,  32'h0000_BEEF, 3};

        ram[32'h100] = 8'h11;
        ram[32'h101] = 8'h22;
        ram[32'h102] = 8'h33;
        ram[32'h103] = 8'h44;
        ram[32'h000] = 8'h80;

        rst = 1'b1;
        rw_mem = 3'b000;
        addr_to_mem = 32'd0;
        data_to_mem = 32'd0;
        quantity = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_status", 40'(mem_status), 40'(2'b00));
        check("rst_mem_a", 40'(mem_a), 40'd0);
        check("rst_mem_wr", 40'(mem_wr), 40'd0);
        check("rst_mem_dout", 40'(mem_dout), 40'd0);
        check("rst_data", 40'(data_from_mem), 40'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Reset lands on the second BUSY cycle of a 4-byte write.
        @(posedge clk); #1;
        rw_mem = 3'b010; addr_to_mem = 32'h500; data_to_mem = 32'h0102_0304; quantity = 4'd4;
        exp_q.push_back({32'h500, 8'h04});
        exp_q.push_back({32'h501, 8'h03});
        @(posedge clk); #1;
        rw_mem = 3'b000;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_status", 40'(mem_status), 40'(2'b00));
        check("abort_mem_a", 40'(mem_a), 40'd0);
        check("abort_mem_wr", 40'(mem_wr), 40'd0);
        check("abort_mem_dout", 40'(mem_dout), 40'd0);
        check("abort_data", 40'(data_from_mem), 40'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("abort_stays_idle", 40'(mem_status), 40'(2'b00));
        end

        // Request held across DONE: one DONE, one IDLE, then a fresh access.
        seq_exp = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
        exp_done_q.push_back({1'b1, 32'h0000_00BE});
        exp_done_q.push_back({1'b1, 32'h0000_00BE});
        rw_mem = 3'b001; addr_to_mem = 32'h0; quantity = 4'd1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("held_req_status", 40'(mem_status), 40'(seq_exp[i]));
            if (i == 4) rw_mem = 3'b000;
        end

        // Illegal request codes in IDLE do nothing.
        for (int i = 0; i < 6; i++) begin
            rw_mem = (i < 3) ? 3'b011 : 3'b111;
            addr_to_mem = 32'h0000_0700;
            @(posedge clk); #1;
            check("illegal_status", 40'(mem_status), 40'(2'b00));
            check("illegal_mem_a", 40'(mem_a), 40'd0);
        end
        rw_mem = 3'b000;
        repeat (2) @(posedge clk);
        #1;

        check("writes_drained", 40'(exp_q.size()), 40'd0);
        check("dones_drained", 40'(exp_done_q.size()), 40'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
